// File: rtl/reel_seed_gen_if.sv
// reel_seed_gen_if: game-control inputs and captured-seed outputs shared
// between the game controller (master) and the seed generator (slave).
interface reel_seed_gen_if #(
    parameter int WIDTH     = 3,
    parameter int NUM_REELS = 3
);
    logic [WIDTH-1:0]           initial_seed;
    logic                       run_game;
    logic [NUM_REELS*WIDTH-1:0] seed;
    logic                       busy;
    logic                       seed_valid;

    modport master (
        output initial_seed,
        output run_game,
        input  seed,
        input  busy,
        input  seed_valid
    );

    modport slave (
        input  initial_seed,
        input  run_game,
        output seed,
        output busy,
        output seed_valid
    );
endinterface

// File: rtl/reel_seed_gen.sv
// reel_seed_gen: one free-running pseudo-random generator per reel. A rising
// edge on run_game latches the reels one after another, STAGGER cycles apart,
// so the reels stop at different times; seed_valid pulses once all are held.
module reel_seed_gen #(
    parameter int               WIDTH     = 3,
    parameter int               NUM_REELS = 3,
    parameter int               STAGGER   = 4,
    parameter int               MODE      = 0,
    parameter logic [WIDTH-1:0] TAPS      = WIDTH'(3'b110)
) (
    input  logic           clk,
    input  logic           rst_n,
    reel_seed_gen_if.slave bus
);

    localparam int TIMER_W = (STAGGER > 1) ? $clog2(STAGGER) : 1;
    localparam int IDX_W   = (NUM_REELS > 1) ? $clog2(NUM_REELS) : 1;

    localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(STAGGER - 1);
    localparam logic [IDX_W-1:0]   IDX_LAST   = IDX_W'(NUM_REELS - 1);
    localparam logic [WIDTH-1:0]   ONE        = WIDTH'(1);

    typedef enum logic {
        IDLE,
        CAPTURE
    } state_t;

    state_t                     state_q;
    logic [TIMER_W-1:0]         timer_q;
    logic [IDX_W-1:0]           reelIdx_q;
    logic                       run_q;
    logic [NUM_REELS*WIDTH-1:0] seed_q;
    logic                       busy_q;
    logic                       seedValid_q;

    logic [WIDTH-1:0] gen_q  [NUM_REELS];
    logic [WIDTH-1:0] gen_d  [NUM_REELS];
    logic [WIDTH-1:0] capVal [NUM_REELS];
    logic [WIDTH-1:0] oddStep;

    // Reset value of each generator: reels start on distinct values, and the
    // LFSR start values skip the all-zero lock-up state.
    function automatic logic [WIDTH-1:0] genResetValue(input int idx);
        if (MODE == 1) begin
            return WIDTH'((idx % ((1 << WIDTH) - 1)) + 1);
        end
        return WIDTH'(idx);
    endfunction

    // Next generator value and the value each reel would capture right now.
    always_comb begin
        oddStep = bus.initial_seed | ONE;
        for (int i = 0; i < NUM_REELS; i++) begin
            gen_d[i]  = gen_q[i];
            capVal[i] = gen_q[i];
            if (MODE == 1) begin
                if (gen_q[i] == '0) begin
                    gen_d[i] = ONE;
                end else if (gen_q[i][0]) begin
                    gen_d[i] = (gen_q[i] >> 1) ^ TAPS;
                end else begin
                    gen_d[i] = gen_q[i] >> 1;
                end
                capVal[i] = gen_q[i] ^ bus.initial_seed;
            end else begin
                gen_d[i] = gen_q[i] + oddStep + WIDTH'(2 * i);
            end
        end
    end

    // Generators run freely every cycle, independent of the capture FSM.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_REELS; i++) begin
                gen_q[i] <= genResetValue(i);
            end
        end else begin
            for (int i = 0; i < NUM_REELS; i++) begin
                gen_q[i] <= gen_d[i];
            end
        end
    end

    // Capture FSM: start edge detection, staggered reel latching, outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            timer_q     <= '0;
            reelIdx_q   <= '0;
            run_q       <= 1'b1;
            seed_q      <= '0;
            busy_q      <= 1'b0;
            seedValid_q <= 1'b0;
        end else begin
            run_q       <= bus.run_game;
            seedValid_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (bus.run_game && !run_q) begin
                        seed_q[0 +: WIDTH] <= capVal[0];
                        if (NUM_REELS == 1) begin
                            seedValid_q <= 1'b1;
                        end else begin
                            state_q   <= CAPTURE;
                            busy_q    <= 1'b1;
                            reelIdx_q <= IDX_W'(1);
                            timer_q   <= '0;
                        end
                    end
                end
                CAPTURE: begin
                    if (timer_q == TIMER_LAST) begin
                        timer_q   <= '0;
                        reelIdx_q <= reelIdx_q + IDX_W'(1);
                        for (int i = 0; i < NUM_REELS; i++) begin
                            if (reelIdx_q == IDX_W'(i)) begin
                                seed_q[i*WIDTH +: WIDTH] <= capVal[i];
                            end
                        end
                        if (reelIdx_q == IDX_LAST) begin
                            state_q     <= IDLE;
                            busy_q      <= 1'b0;
                            seedValid_q <= 1'b1;
                        end
                    end else begin
                        timer_q <= timer_q + TIMER_W'(1);
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.seed       = seed_q;
    assign bus.busy       = busy_q;
    assign bus.seed_valid = seedValid_q;

endmodule

// File: tb/tb_reel_seed_gen.sv
// tb_reel_seed_gen: scoreboard bench for reel_seed_gen in three
// configurations (default odd-step, Galois LFSR, single reel).
module tb_reel_seed_gen;

    logic clk;
    logic rst0_n;
    logic rst1_n;
    logic rst2_n;

    int testsRun    = 0;
    int testsFailed = 0;

    logic [8:0] expQ0 [$];
    logic [8:0] expQ1 [$];
    logic [2:0] expQ2 [$];

    reel_seed_gen_if #(.WIDTH(3), .NUM_REELS(3)) bus0 ();
    reel_seed_gen_if #(.WIDTH(3), .NUM_REELS(3)) bus1 ();
    reel_seed_gen_if #(.WIDTH(3), .NUM_REELS(1)) bus2 ();

    reel_seed_gen #(.WIDTH(3), .NUM_REELS(3), .STAGGER(4), .MODE(0), .TAPS(3'b110))
        dut0 (.clk(clk), .rst_n(rst0_n), .bus(bus0));
    reel_seed_gen #(.WIDTH(3), .NUM_REELS(3), .STAGGER(4), .MODE(1), .TAPS(3'b110))
        dut1 (.clk(clk), .rst_n(rst1_n), .bus(bus1));
    reel_seed_gen #(.WIDTH(3), .NUM_REELS(1), .STAGGER(1), .MODE(0), .TAPS(3'b110))
        dut2 (.clk(clk), .rst_n(rst2_n), .bus(bus2));

    // Free-running 10-unit clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        testsRun++;
        if (actual !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Scoreboard monitors: every seed_valid pulse must match the oldest
    // pending expected seed of that instance.
    always @(negedge clk) begin
        if (bus0.seed_valid === 1'b1) begin
            checkOutput("dut0 seed_valid has pending expectation", 32'(expQ0.size() != 0), 32'd1);
            if (expQ0.size() != 0) checkOutput("dut0 scoreboard seed", 32'(bus0.seed), 32'(expQ0.pop_front()));
        end
    end

    always @(negedge clk) begin
        if (bus1.seed_valid === 1'b1) begin
            checkOutput("dut1 seed_valid has pending expectation", 32'(expQ1.size() != 0), 32'd1);
            if (expQ1.size() != 0) checkOutput("dut1 scoreboard seed", 32'(bus1.seed), 32'(expQ1.pop_front()));
        end
    end

    always @(negedge clk) begin
        if (bus2.seed_valid === 1'b1) begin
            checkOutput("dut2 seed_valid has pending expectation", 32'(expQ2.size() != 0), 32'd1);
            if (expQ2.size() != 0) checkOutput("dut2 scoreboard seed", 32'(bus2.seed), 32'(expQ2.pop_front()));
        end
    end

    // Default round, initial_seed=3, start at edge 5: reel0=4 @5, reel1=1 @9, reel2=6 @13.
    function automatic logic [8:0] expSeed0(input int e);
        if (e < 5)  return 9'd0;
        if (e < 9)  return 9'b000_000_100;
        if (e < 13) return 9'b000_001_100;
        return 9'b110_001_100;
    endfunction

    // pattern 0: plain start at edge 5; 1: low pulse at edge 7 then held high;
    // 2: held high through reset, low at edge 4, high again from edge 5.
    function automatic logic runVal0(input int pattern, input int e);
        if (pattern == 1) return (e >= 5) && (e != 7);
        if (pattern == 2) return (e != 4);
        return (e >= 5);
    endfunction

    task automatic applyStimulus(input int pattern, input int abortEdge, input bit expectDone);
        rst0_n            = 1'b0;
        bus0.initial_seed = 3'd3;
        bus0.run_game     = (pattern == 2);
        repeat (2) @(negedge clk);
        checkOutput("dut0 reset seed", 32'(bus0.seed), 32'd0);
        checkOutput("dut0 reset busy", 32'(bus0.busy), 32'd0);
        checkOutput("dut0 reset seed_valid", 32'(bus0.seed_valid), 32'd0);
        rst0_n = 1'b1;
        if (expectDone) expQ0.push_back(9'b110_001_100);
        for (int e = 1; e <= 20; e++) begin
            bus0.run_game = runVal0(pattern, e);
            tick();
            checkOutput($sformatf("dut0 seed after edge %0d", e), 32'(bus0.seed), 32'(expSeed0(e)));
            checkOutput($sformatf("dut0 busy after edge %0d", e), 32'(bus0.busy), 32'((e >= 5) && (e <= 12)));
            checkOutput($sformatf("dut0 seed_valid after edge %0d", e), 32'(bus0.seed_valid), 32'(e == 13));
            if (e == abortEdge) begin
                #2 rst0_n = 1'b0;
                #1;
                checkOutput("dut0 async reset seed", 32'(bus0.seed), 32'd0);
                checkOutput("dut0 async reset busy", 32'(bus0.busy), 32'd0);
                checkOutput("dut0 async reset seed_valid", 32'(bus0.seed_valid), 32'd0);
                repeat (3) tick();
                break;
            end
        end
    endtask

    // LFSR round 1: initial_seed=5, start @2 -> {0,0,3}; round 2: initial_seed=2, start @12 -> {3,3,7}.
    function automatic logic [8:0] expSeed1(input int e);
        if (e < 2)  return 9'd0;
        if (e < 12) return 9'b000_000_011;
        if (e < 16) return 9'b000_000_111;
        if (e < 20) return 9'b000_011_111;
        return 9'b011_011_111;
    endfunction

    task automatic applyLfsr();
        logic [2:0] lfsrSeq [8];
        lfsrSeq = '{3'd1, 3'd6, 3'd3, 3'd7, 3'd5, 3'd4, 3'd2, 3'd1};
        rst1_n            = 1'b0;
        bus1.initial_seed = 3'd0;
        bus1.run_game     = 1'b0;
        repeat (2) @(negedge clk);
        rst1_n = 1'b1;
        checkOutput("dut1 gen0 step 0", 32'(dut1.gen_q[0]), 32'(lfsrSeq[0]));
        for (int k = 1; k < 8; k++) begin
            tick();
            checkOutput($sformatf("dut1 gen0 step %0d", k), 32'(dut1.gen_q[0]), 32'(lfsrSeq[k]));
        end

        rst1_n            = 1'b0;
        bus1.initial_seed = 3'd5;
        repeat (2) @(negedge clk);
        checkOutput("dut1 reset seed", 32'(bus1.seed), 32'd0);
        rst1_n = 1'b1;
        expQ1.push_back(9'b000_000_011);
        expQ1.push_back(9'b011_011_111);
        for (int e = 1; e <= 24; e++) begin
            bus1.initial_seed = (e <= 10) ? 3'd5 : 3'd2;
            bus1.run_game     = ((e >= 2) && (e <= 10)) || (e >= 12);
            tick();
            checkOutput($sformatf("dut1 seed after edge %0d", e), 32'(bus1.seed), 32'(expSeed1(e)));
            checkOutput($sformatf("dut1 busy after edge %0d", e), 32'(bus1.busy),
                        32'(((e >= 2) && (e <= 9)) || ((e >= 12) && (e <= 19))));
            checkOutput($sformatf("dut1 seed_valid after edge %0d", e), 32'(bus1.seed_valid),
                        32'((e == 10) || (e == 20)));
        end
    endtask

    // Single reel, initial_seed=3: gen after n edges is 3n mod 8; starts at edges 3 and 7.
    task automatic applySingle();
        rst2_n            = 1'b0;
        bus2.initial_seed = 3'd3;
        bus2.run_game     = 1'b0;
        repeat (2) @(negedge clk);
        checkOutput("dut2 reset seed", 32'(bus2.seed), 32'd0);
        rst2_n = 1'b1;
        expQ2.push_back(3'd6);
        expQ2.push_back(3'd2);
        for (int e = 1; e <= 10; e++) begin
            bus2.run_game = ((e >= 3) && (e <= 5)) || (e >= 7);
            tick();
            checkOutput($sformatf("dut2 seed after edge %0d", e), 32'(bus2.seed),
                        (e < 3) ? 32'd0 : ((e < 7) ? 32'd6 : 32'd2));
            checkOutput($sformatf("dut2 busy after edge %0d", e), 32'(bus2.busy), 32'd0);
            checkOutput($sformatf("dut2 seed_valid after edge %0d", e), 32'(bus2.seed_valid),
                        32'((e == 3) || (e == 7)));
        end
    endtask

    // Test sequence: all three instances start in reset and are exercised in turn.
    initial begin
        rst0_n            = 1'b0;
        rst1_n            = 1'b0;
        rst2_n            = 1'b0;
        bus0.initial_seed = 3'd0;
        bus0.run_game     = 1'b0;
        bus1.initial_seed = 3'd0;
        bus1.run_game     = 1'b0;
        bus2.initial_seed = 3'd0;
        bus2.run_game     = 1'b0;

        applyStimulus(1, 0, 1'b1);
        applyStimulus(2, 0, 1'b1);
        applyStimulus(0, 11, 1'b0);
        applyStimulus(0, 0, 1'b1);
        applyLfsr();
        applySingle();
        repeat (3) tick();

        checkOutput("dut0 scoreboard drained", 32'(expQ0.size()), 32'd0);
        checkOutput("dut1 scoreboard drained", 32'(expQ1.size()), 32'd0);
        checkOutput("dut2 scoreboard drained", 32'(expQ2.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
